// File: rtl/debug_unit.sv
// debug_unit: breakpoint / halt / single-step controller sitting between the
// coprocessor debug bus and the core pipeline stall input.
//
// Ports:
//   clk, reset         system clock, asynchronous active-high reset
//   dbgAddr            debug bus address; [12] selects this block, [4:0] is the word index
//   dbgWrite, dbgRead  one-cycle access strobes
//   dbgWriteData       write data
//   dbgReadData        registered read data, held until the next read
//   dbgReadValid       one-cycle pulse, one cycle after dbgRead
//   pc, cycleCount     fetch PC and cycle CSR, compared against breakpoint values
//   retire, ebreak     instruction-retired pulse, ebreak decoded
//   coreStall, halted  pipeline freeze, halted status
//   debugFlags         {sticky ebreak-seen, coreStall}
//
// Register map (word index): 0 CTRL, 1 HITCNT, 2+2i BPVAL[i], 3+2i BPCFG[i].
module debug_unit #(
    parameter int unsigned N      = 64,
    parameter int unsigned NUM_BP = 4,
    parameter int unsigned ADDR_W = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] dbgAddr,
    input  logic              dbgWrite,
    input  logic              dbgRead,
    input  logic [N-1:0]      dbgWriteData,
    output logic [N-1:0]      dbgReadData,
    output logic              dbgReadValid,
    input  logic [N-1:0]      pc,
    input  logic [N-1:0]      cycleCount,
    input  logic              retire,
    input  logic              ebreak,
    output logic              coreStall,
    output logic              halted,
    output logic [1:0]        debugFlags
);

    typedef enum logic [1:0] {
        StRun    = 2'b00,
        StHalted = 2'b01,
        StStep   = 2'b10
    } state_t;

    localparam logic [2:0] CauseHalt   = 3'd0;
    localparam logic [2:0] CauseEbreak = 3'd1;
    localparam logic [2:0] CauseStep   = 3'd6;

    state_t        stateQ, stateD;
    logic [2:0]    causeQ, causeD;
    logic          maskQ;
    logic          seenQ;
    logic [N-1:0]  hitCntQ;
    logic [N-1:0]  bpValQ [NUM_BP];
    logic [2:0]    bpCfgQ [NUM_BP];
    logic [N-1:0]  rdDataQ;
    logic          rdValidQ;

    // ---------------- bus decode ----------------
    logic       sel;
    logic [4:0] wordIdx;
    logic       ctrlWr, hitCntWr;
    logic       haltReq, resumeReq, stepReq, clearSeen;
    logic       unusedAddr;

    assign sel        = dbgAddr[12];
    assign wordIdx    = dbgAddr[4:0];
    assign unusedAddr = ^{dbgAddr[ADDR_W-1:13], dbgAddr[11:5]};

    assign ctrlWr    = dbgWrite && sel && (wordIdx == 5'd0);
    assign hitCntWr  = dbgWrite && sel && (wordIdx == 5'd1);
    assign haltReq   = ctrlWr && dbgWriteData[0];
    assign resumeReq = ctrlWr && dbgWriteData[1];
    assign stepReq   = ctrlWr && dbgWriteData[2];
    assign clearSeen = ctrlWr && dbgWriteData[3];

    logic [NUM_BP-1:0] bpValWr, bpCfgWr;

    always_comb begin
        bpValWr = '0;
        bpCfgWr = '0;
        for (int i = 0; i < NUM_BP; i++) begin
            bpValWr[i] = dbgWrite && sel && (wordIdx == 5'(2 + 2 * i));
            bpCfgWr[i] = dbgWrite && sel && (wordIdx == 5'(3 + 2 * i));
        end
    end

    // ---------------- breakpoint match ----------------
    logic [NUM_BP-1:0] hitVec;
    logic              anyHit;
    logic [2:0]        hitIdx;
    logic [2:0]        bpCause;

    always_comb begin
        hitVec = '0;
        anyHit = 1'b0;
        hitIdx = 3'd0;
        for (int i = 0; i < NUM_BP; i++) begin
            // Mode 11 is reserved and behaves as off.
            unique case (bpCfgQ[i][1:0])
                2'b01:   hitVec[i] = (pc == bpValQ[i]) && !maskQ;
                2'b10:   hitVec[i] = (cycleCount == bpValQ[i]);
                default: hitVec[i] = 1'b0;
            endcase
            hitVec[i] = hitVec[i] && (stateQ == StRun);
        end
        // Lowest-numbered hitting channel names the cause.
        for (int i = 0; i < NUM_BP; i++) begin
            if (hitVec[i] && !anyHit) begin
                anyHit = 1'b1;
                hitIdx = 3'(i);
            end
        end
        bpCause = (hitIdx >= 3'd5) ? 3'd7 : hitIdx + 3'd2;
    end

    // ---------------- control FSM ----------------
    logic bpHalt;

    always_comb begin
        stateD = stateQ;
        causeD = causeQ;
        bpHalt = 1'b0;
        unique case (stateQ)
            StRun: begin
                if (ebreak) begin
                    stateD = StHalted;
                    causeD = CauseEbreak;
                end else if (anyHit) begin
                    stateD = StHalted;
                    causeD = bpCause;
                    bpHalt = 1'b1;
                end else if (haltReq) begin
                    stateD = StHalted;
                    causeD = CauseHalt;
                end
            end
            StHalted: begin
                if (stepReq) begin
                    stateD = StStep;
                end else if (resumeReq) begin
                    stateD = StRun;
                end
            end
            StStep: begin
                if (ebreak) begin
                    stateD = StHalted;
                    causeD = CauseEbreak;
                end else if (retire) begin
                    stateD = StHalted;
                    causeD = CauseStep;
                end
            end
            default: stateD = StRun;
        endcase
    end

    logic              runHalt, leaveHalt;
    logic [NUM_BP-1:0] oneShotClr;

    assign runHalt   = (stateQ == StRun) && (stateD == StHalted);
    assign leaveHalt = (stateQ == StHalted) && (stateD != StHalted);

    always_comb begin
        oneShotClr = '0;
        for (int i = 0; i < NUM_BP; i++) begin
            oneShotClr[i] = runHalt && hitVec[i] && bpCfgQ[i][2];
        end
    end

    // ---------------- read mux ----------------
    logic [N-1:0] rdMux;

    always_comb begin
        rdMux = '0;
        if (sel) begin
            if (wordIdx == 5'd0) begin
                rdMux = N'({causeQ, stateQ});
            end else if (wordIdx == 5'd1) begin
                rdMux = hitCntQ;
            end else begin
                for (int i = 0; i < NUM_BP; i++) begin
                    if (wordIdx == 5'(2 + 2 * i)) rdMux = bpValQ[i];
                    if (wordIdx == 5'(3 + 2 * i)) rdMux = N'(bpCfgQ[i]);
                end
            end
        end
    end

    // ---------------- state ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stateQ   <= StRun;
            causeQ   <= 3'd0;
            maskQ    <= 1'b0;
            seenQ    <= 1'b0;
            hitCntQ  <= '0;
            rdDataQ  <= '0;
            rdValidQ <= 1'b0;
            for (int i = 0; i < NUM_BP; i++) begin
                bpValQ[i] <= '0;
                bpCfgQ[i] <= 3'b000;
            end
        end else begin
            stateQ   <= stateD;
            causeQ   <= causeD;
            rdValidQ <= dbgRead;
            if (dbgRead) rdDataQ <= rdMux;

            // Mask keeps a resumed core from re-hitting the PC it stopped on.
            if (leaveHalt) maskQ <= 1'b1;
            else if (retire) maskQ <= 1'b0;

            if (ebreak) seenQ <= 1'b1;
            else if (clearSeen) seenQ <= 1'b0;

            if (hitCntWr) hitCntQ <= '0;
            else if (bpHalt) hitCntQ <= hitCntQ + N'(1);

            for (int i = 0; i < NUM_BP; i++) begin
                if (bpValWr[i]) bpValQ[i] <= dbgWriteData;
                if (oneShotClr[i]) bpCfgQ[i] <= 3'b000;
                else if (bpCfgWr[i]) bpCfgQ[i] <= dbgWriteData[2:0];
            end
        end
    end

    assign coreStall    = (stateQ == StHalted);
    assign halted       = (stateQ == StHalted);
    assign debugFlags   = {seenQ, coreStall};
    assign dbgReadData  = rdDataQ;
    assign dbgReadValid = rdValidQ;

endmodule

// File: tb/tb_debug_unit.sv
// Self-checking bench for debug_unit: directed scenarios followed by a
// randomized run scored against a behavioural model.
module tb_debug_unit;

    localparam int N      = 64;
    localparam int NUM_BP = 4;
    localparam int ADDR_W = 15;

    logic              clk = 1'b0;
    logic              reset;
    logic [ADDR_W-1:0] dbgAddr;
    logic              dbgWrite, dbgRead;
    logic [N-1:0]      dbgWriteData, dbgReadData;
    logic              dbgReadValid;
    logic [N-1:0]      pc, cycleCount;
    logic              retire, ebreak;
    logic              coreStall, halted;
    logic [1:0]        debugFlags;

    int testsRun    = 0;
    int testsFailed = 0;

    debug_unit #(.N(N), .NUM_BP(NUM_BP), .ADDR_W(ADDR_W)) dut (
        .clk          (clk),
        .reset        (reset),
        .dbgAddr      (dbgAddr),
        .dbgWrite     (dbgWrite),
        .dbgRead      (dbgRead),
        .dbgWriteData (dbgWriteData),
        .dbgReadData  (dbgReadData),
        .dbgReadValid (dbgReadValid),
        .pc           (pc),
        .cycleCount   (cycleCount),
        .retire       (retire),
        .ebreak       (ebreak),
        .coreStall    (coreStall),
        .halted       (halted),
        .debugFlags   (debugFlags)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout want finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic dbgWr(input int idx, input logic [N-1:0] d);
        dbgAddr      = ADDR_W'(32'h1000 | idx);
        dbgWriteData = d;
        dbgWrite     = 1'b1;
        tick();
        dbgWrite     = 1'b0;
    endtask

    task automatic dbgRd(input int idx, output logic [N-1:0] d);
        dbgAddr = ADDR_W'(32'h1000 | idx);
        dbgRead = 1'b1;
        tick();
        dbgRead = 1'b0;
        d       = dbgReadData;
    endtask

    task automatic doReset();
        dbgAddr = '0; dbgWrite = 0; dbgRead = 0; dbgWriteData = '0;
        pc = 64'h1000; cycleCount = '0; retire = 0; ebreak = 0;
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    // ---------------- directed scenarios ----------------
    task automatic test_reset();
        doReset();
        testsRun++;
        if ({coreStall, halted, dbgReadValid, debugFlags} !== 5'b0) begin
            testsFailed++;
            $display("FAIL reset_outputs: got %b want 00000",
                     {coreStall, halted, dbgReadValid, debugFlags});
        end
        testsRun++;
        if (dbgReadData !== '0) begin
            testsFailed++; $display("FAIL reset_rdata: got %0h want 0", dbgReadData);
        end
    endtask

    task automatic test_pc_breakpoint();
        logic [N-1:0] d;
        dbgWr(2, 64'h40);
        dbgWr(3, 64'h1);
        pc = 64'h3c;
        tick();
        testsRun++;
        if (halted !== 1'b0) begin
            testsFailed++; $display("FAIL pc_nohit: halted got %b want 0", halted);
        end
        pc = 64'h40;
        tick();
        testsRun++;
        if ({halted, coreStall} !== 2'b11) begin
            testsFailed++; $display("FAIL pc_hit: halted/stall got %b want 11", {halted, coreStall});
        end
        dbgRd(0, d);
        testsRun++;
        if (d !== 64'd9 || dbgReadValid !== 1'b1) begin
            testsFailed++; $display("FAIL pc_ctrl: got %0h/%b want 9/1", d, dbgReadValid);
        end
        tick();
        testsRun++;
        if (dbgReadValid !== 1'b0 || dbgReadData !== 64'd9) begin
            testsFailed++;
            $display("FAIL rvalid_pulse: got %b/%0h want 0/9", dbgReadValid, dbgReadData);
        end
        dbgRd(1, d);
        testsRun++;
        if (d !== 64'd1) begin
            testsFailed++; $display("FAIL pc_hitcnt: got %0d want 1", d);
        end
    endtask

    task automatic test_resume_mask();
        logic [N-1:0] d;
        dbgWr(0, 64'h2);
        for (int i = 0; i < 3; i++) begin
            tick();
            testsRun++;
            if (halted !== 1'b0) begin
                testsFailed++; $display("FAIL mask_hold%0d: halted got %b want 0", i, halted);
            end
        end
        retire = 1'b1;
        tick();
        retire = 1'b0;
        pc     = 64'h44;
        tick();
        testsRun++;
        if (halted !== 1'b0) begin
            testsFailed++; $display("FAIL mask_retire: halted got %b want 0", halted);
        end
        pc = 64'h40;
        tick();
        testsRun++;
        if (halted !== 1'b1) begin
            testsFailed++; $display("FAIL rehit: halted got %b want 1", halted);
        end
        dbgRd(1, d);
        testsRun++;
        if (d !== 64'd2) begin
            testsFailed++; $display("FAIL rehit_hitcnt: got %0d want 2", d);
        end
    endtask

    task automatic test_cycle_oneshot();
        logic [N-1:0] d;
        dbgWr(3, 64'h0);
        dbgWr(4, 64'd100);
        dbgWr(5, 64'h6);
        cycleCount = 64'd50;
        pc         = 64'h80;
        dbgWr(0, 64'h2);
        for (int c = 95; c < 100; c++) begin
            cycleCount = N'(c);
            tick();
            testsRun++;
            if (halted !== 1'b0) begin
                testsFailed++; $display("FAIL cyc_early%0d: halted got %b want 0", c, halted);
            end
        end
        cycleCount = 64'd100;
        tick();
        testsRun++;
        if (halted !== 1'b1) begin
            testsFailed++; $display("FAIL cyc_hit: halted got %b want 1", halted);
        end
        dbgRd(0, d);
        testsRun++;
        if (d !== 64'd13) begin
            testsFailed++; $display("FAIL cyc_ctrl: got %0d want 13", d);
        end
        dbgRd(5, d);
        testsRun++;
        if (d !== 64'd0) begin
            testsFailed++; $display("FAIL oneshot_cfg: got %0d want 0", d);
        end
        dbgWr(0, 64'h2);
        tick();
        cycleCount = 64'd101;
        tick();
        testsRun++;
        if (halted !== 1'b0) begin
            testsFailed++; $display("FAIL oneshot_rehit: halted got %b want 0", halted);
        end
    endtask

    task automatic test_step();
        logic [N-1:0] d;
        dbgWr(0, 64'h1);
        testsRun++;
        if (halted !== 1'b1) begin
            testsFailed++; $display("FAIL ext_halt: halted got %b want 1", halted);
        end
        dbgWr(0, 64'h4);
        for (int i = 0; i < 3; i++) begin
            testsRun++;
            if ({halted, coreStall} !== 2'b00) begin
                testsFailed++;
                $display("FAIL step_run%0d: halted/stall got %b want 00", i, {halted, coreStall});
            end
            if (i < 2) tick();
        end
        retire = 1'b1;
        tick();
        retire = 1'b0;
        testsRun++;
        if ({halted, coreStall} !== 2'b11) begin
            testsFailed++;
            $display("FAIL step_done: halted/stall got %b want 11", {halted, coreStall});
        end
        dbgRd(0, d);
        testsRun++;
        if (d !== 64'd25) begin
            testsFailed++; $display("FAIL step_cause: got %0d want 25", d);
        end
        dbgWr(0, 64'h6);
        dbgRd(0, d);
        testsRun++;
        if (d !== 64'd26) begin
            testsFailed++; $display("FAIL step_wins: got %0d want 26", d);
        end
        retire = 1'b1;
        tick();
        retire = 1'b0;
        testsRun++;
        if (halted !== 1'b1) begin
            testsFailed++; $display("FAIL step2_done: halted got %b want 1", halted);
        end
    endtask

    task automatic test_priority();
        logic [N-1:0] d;
        dbgWr(3, 64'h1);
        pc = 64'h200;
        dbgWr(0, 64'h2);
        retire = 1'b1;
        tick();
        retire = 1'b0;
        pc           = 64'h40;
        ebreak       = 1'b1;
        dbgAddr      = ADDR_W'(32'h1000);
        dbgWriteData = 64'h1;
        dbgWrite     = 1'b1;
        tick();
        ebreak   = 1'b0;
        dbgWrite = 1'b0;
        testsRun++;
        if (debugFlags !== 2'b11) begin
            testsFailed++; $display("FAIL prio_flags: got %b want 11", debugFlags);
        end
        dbgRd(0, d);
        testsRun++;
        if (d !== 64'd5) begin
            testsFailed++; $display("FAIL prio_cause: got %0d want 5", d);
        end
        dbgRd(1, d);
        testsRun++;
        if (d !== 64'd3) begin
            testsFailed++; $display("FAIL prio_hitcnt: got %0d want 3", d);
        end
        dbgWr(0, 64'h8);
        testsRun++;
        if (debugFlags !== 2'b01) begin
            testsFailed++; $display("FAIL seen_clear: got %b want 01", debugFlags);
        end
    endtask

    task automatic test_reset_in_step();
        logic [N-1:0] d;
        dbgWr(5, 64'h2);
        ebreak = 1'b1;
        tick();
        ebreak = 1'b0;
        dbgRd(1, d);
        dbgWr(0, 64'h4);
        testsRun++;
        if ({halted, debugFlags} !== 3'b010) begin
            testsFailed++; $display("FAIL pre_reset: got %b want 010", {halted, debugFlags});
        end
        #2;
        reset = 1'b1;
        #1;
        testsRun++;
        if ({coreStall, halted, dbgReadValid, debugFlags} !== 5'b0 || dbgReadData !== '0) begin
            testsFailed++;
            $display("FAIL async_reset: got %b/%0h want 00000/0",
                     {coreStall, halted, dbgReadValid, debugFlags}, dbgReadData);
        end
        tick();
        reset = 1'b0;
        dbgRd(5, d);
        testsRun++;
        if (d !== 64'd0) begin
            testsFailed++; $display("FAIL reset_cfg: got %0d want 0", d);
        end
        dbgRd(0, d);
        testsRun++;
        if (d !== 64'd0) begin
            testsFailed++; $display("FAIL reset_ctrl: got %0d want 0", d);
        end
    endtask

    // ---------------- behavioural model ----------------
    localparam int MRun = 0, MHalted = 1, MStep = 2;

    int           mState, mCause;
    bit           mMask, mSeen, mRdV;
    logic [N-1:0] mHitCnt, mRd;
    logic [N-1:0] mVal [NUM_BP];
    int           mCfg [NUM_BP];

    function automatic logic [N-1:0] mRegValue(input int idx);
        if (idx == 0) return N'(mCause * 4 + mState);
        if (idx == 1) return mHitCnt;
        if (idx >= 2 && idx < 2 + 2 * NUM_BP) begin
            if (idx % 2 == 0) return mVal[(idx - 2) / 2];
            return N'(mCfg[(idx - 2) / 2]);
        end
        return '0;
    endfunction

    task automatic modelReset();
        mState = MRun; mCause = 0; mMask = 0; mSeen = 0; mRdV = 0;
        mHitCnt = '0; mRd = '0;
        for (int i = 0; i < NUM_BP; i++) begin
            mVal[i] = '0;
            mCfg[i] = 0;
        end
    endtask

    task automatic modelCycle(input bit wr, input bit rd, input logic [ADDR_W-1:0] a,
                              input logic [N-1:0] wd, input logic [N-1:0] pcv,
                              input logic [N-1:0] cyc, input bit ret, input bit ebk);
        int  idx    = int'(a[4:0]);
        bit  mapped = a[12];
        bit  ctrl   = wr && mapped && idx == 0;
        int  next   = mState;
        int  hits[$];
        int  oldCfg [NUM_BP];
        if (rd) mRd = mapped ? mRegValue(idx) : '0;
        mRdV = rd;
        for (int i = 0; i < NUM_BP; i++) begin
            oldCfg[i] = mCfg[i];
            if (mState == MRun) begin
                if ((mCfg[i] % 4 == 1 && pcv == mVal[i] && !mMask) ||
                    (mCfg[i] % 4 == 2 && cyc == mVal[i])) hits.push_back(i);
            end
        end
        if (mState == MRun) begin
            if (ebk) begin
                next = MHalted; mCause = 1;
            end else if (hits.size() > 0) begin
                next = MHalted;
                mCause = (hits[0] + 2 > 7 || hits[0] >= 5) ? 7 : hits[0] + 2;
                mHitCnt = mHitCnt + 1;
            end else if (ctrl && wd[0]) begin
                next = MHalted; mCause = 0;
            end
        end else if (mState == MHalted) begin
            if (ctrl && wd[2]) next = MStep;
            else if (ctrl && wd[1]) next = MRun;
        end else begin
            if (ebk) begin
                next = MHalted; mCause = 1;
            end else if (ret) begin
                next = MHalted; mCause = 6;
            end
        end
        if (mState == MHalted && next != MHalted) mMask = 1;
        else if (ret) mMask = 0;
        if (ebk) mSeen = 1;
        else if (ctrl && wd[3]) mSeen = 0;
        if (wr && mapped) begin
            if (idx == 1) mHitCnt = '0;
            else if (idx >= 2 && idx < 2 + 2 * NUM_BP) begin
                if (idx % 2 == 0) mVal[(idx - 2) / 2] = wd;
                else mCfg[(idx - 2) / 2] = int'(wd[2:0]);
            end
        end
        if (mState == MRun && next == MHalted) begin
            foreach (hits[k]) if (oldCfg[hits[k]] >= 4) mCfg[hits[k]] = 0;
        end
        mState = next;
    endtask

    task automatic test_random();
        logic [ADDR_W-1:0] a;
        logic [N-1:0]      wd;
        int                idx;
        doReset();
        modelReset();
        for (int cyc = 0; cyc < 600; cyc++) begin
            pc         = N'(32'h10 * $urandom_range(1, 4));
            cycleCount = N'($urandom_range(0, 7));
            retire     = ($urandom_range(0, 3) == 0);
            ebreak     = ($urandom_range(0, 24) == 0);
            dbgWrite   = ($urandom_range(0, 3) == 0);
            dbgRead    = ($urandom_range(0, 2) == 0);
            idx        = $urandom_range(0, 2 * NUM_BP + 3);
            a          = ADDR_W'($urandom);
            a[12]      = ($urandom_range(0, 7) != 0);
            a[4:0]     = 5'(idx);
            if (idx >= 2 && idx % 2 == 0)
                wd = ($urandom_range(0, 1) == 1) ? N'(32'h10 * $urandom_range(1, 4))
                                                 : N'($urandom_range(0, 7));
            else if (idx == 0)
                wd = N'($urandom_range(0, 3) == 0 ? 1 : $urandom_range(0, 15));
            else
                wd = N'($urandom_range(0, 15));
            dbgAddr      = a;
            dbgWriteData = wd;
            modelCycle(dbgWrite, dbgRead, a, wd, pc, cycleCount, retire, ebreak);
            tick();
            testsRun++;
            if (halted !== (mState == MHalted) || coreStall !== (mState == MHalted)) begin
                testsFailed++;
                $display("FAIL rand_state cyc%0d: halted/stall got %b%b want state %0d",
                         cyc, halted, coreStall, mState);
            end
            testsRun++;
            if (debugFlags !== {mSeen, mState == MHalted}) begin
                testsFailed++;
                $display("FAIL rand_flags cyc%0d: got %b want %b%b", cyc, debugFlags,
                         mSeen, mState == MHalted);
            end
            testsRun++;
            if (dbgReadValid !== mRdV || dbgReadData !== mRd) begin
                testsFailed++;
                $display("FAIL rand_read cyc%0d: got %b/%0h want %b/%0h", cyc,
                         dbgReadValid, dbgReadData, mRdV, mRd);
            end
        end
        dbgWrite = 1'b0; dbgRead = 1'b0; retire = 1'b0; ebreak = 1'b0;
    endtask

    initial begin
        test_reset();
        test_pc_breakpoint();
        test_resume_mask();
        test_cycle_oneshot();
        test_step();
        test_priority();
        test_reset_in_step();
        test_random();
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/debug_unit.md
Name: debug_unit

Overview:
- Parametrised successor to the core's single cycle-stall comparator and ebreak flag.
- Provides NUM_BP configurable breakpoint channels (PC-match or cycle-match) and a halt/resume/single-step state machine driving the core stall.
- Provides a latched halt cause and a memory-mapped register port for the external coprocessor/debugger.
- Sits between the coprocessor IO bus and the core's pipeline stall input.

Parameters:
- N, 64, data/PC/cycle width.
- NUM_BP, 4, number of breakpoint channels (1..8).
- ADDR_W, 15, debug bus address width.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- dbgAddr  in  ADDR_W  register address; dbgAddr[4:0] is the word index; accesses decode only when dbgAddr[12]=1.
- dbgWrite  in  1  write strobe, one cycle.
- dbgRead  in  1  read strobe, one cycle.
- dbgWriteData  in  N  write data.
- dbgReadData  out  N  registered read data.
- dbgReadValid  out  1  pulses one cycle after dbgRead.
- pc  in  N  PC of the instruction in fetch.
- cycleCount  in  N  current cycle CSR value.
- retire  in  1  instruction-retired pulse.
- ebreak  in  1  ebreak decoded in decode stage.
- coreStall  out  1  freezes the pipeline and the cycle counter.
- halted  out  1  state==HALTED.
- debugFlags  out  2  [0]=coreStall, [1]=sticky ebreak-seen.

Behaviour:
- Register map (word index):
  - 0 CTRL: write bit0=halt, bit1=resume, bit2=step (self-clearing pulses), bit3=clear ebreak-seen. Read returns {cause[2:0], state[1:0]} at bits [4:0].
  - 1 HITCNT: N-bit count of breakpoint halts; wraps; write-clears.
  - 2+2i BPVAL[i]: N-bit compare value.
  - 3+2i BPCFG[i]: [1:0] mode (00 off, 01 PC, 10 cycle, 11 reserved = off); [2] one-shot.
  - Unmapped addresses: reads return 0, writes are ignored.
- Reads: dbgReadData and dbgReadValid update at t+1; dbgReadData holds its value until the next read.
- Channel i hits when enabled and:
  - PC mode: pc==BPVAL[i] and mask==0.
  - Cycle mode: cycleCount==BPVAL[i].
  - Hits are evaluated only in RUN.
- PC mask:
  - Set on any transition out of HALTED.
  - Cleared on the first retire pulse, so a resume does not re-hit the same PC.
- States RUN(00), HALTED(01), STEP(10).
- RUN:
  - coreStall=0.
  - Any trigger (ebreak, channel hit, CTRL.halt) at cycle t causes HALTED and coreStall=1 from t+1.
  - Cause priority on simultaneous triggers: ebreak(1) > breakpoint(2+lowest hit index, capped at 7 for index ≥5) > external halt(0).
  - A breakpoint halt increments HITCNT.
  - A one-shot channel clears its mode to 00 in the same edge that enters HALTED.
- HALTED:
  - coreStall=1.
  - CTRL.resume goes to RUN; CTRL.step goes to STEP.
  - If both are written in one cycle, step wins.
  - CTRL.halt is ignored and cause is unchanged.
- STEP:
  - coreStall=0 until retire, then HALTED with cause=6 (step) and coreStall=1 the next cycle.
  - ebreak during STEP overrides with cause=1.
  - Breakpoints are not evaluated.
- Same-cycle write of halt with resume/step while in RUN: halt wins.
- Resume/step in RUN is ignored.
- ebreak-seen flag:
  - Sets on any ebreak in any state.
  - Cleared only by CTRL bit3 or reset.
  - Set wins if clear coincides.
- Reset (asynchronous, any time including mid-STEP):
  - state=RUN, all BPCFG=0, BPVAL=0, HITCNT=0, cause=0, mask=0.
  - Outputs: coreStall=0, halted=0, dbgReadData=0, dbgReadValid=0, debugFlags=00.
- Register writes are accepted in every state.
- Breakpoint config changes take effect on the following cycle.

Test Plan:
1. Reset, then BPVAL0=0x40, BPCFG0=01, run to pc=0x40: halted=1 and coreStall=1 on the next cycle. CTRL read returns cause=2, state=01; HITCNT=1.
2. From (1), write CTRL.resume with pc held at 0x40 until retire: no re-halt. pc later returns to 0x40: halts again, HITCNT=2.
3. BPCFG1=110 (cycle, one-shot), BPVAL1=100: halts when cycleCount=100, cause=3, BPCFG1 reads 000. Resume; run past 100 again: no halt.
4. Halted, write CTRL.step: coreStall drops for exactly the cycles until one retire pulse, then halted=1 with cause=6. Step and resume written together: enters STEP.
5. ebreak coincident with a PC hit on channel 0 and an external halt write: cause=1, HITCNT unchanged, debugFlags=11. Write CTRL bit3: debugFlags[1]=0.
6. Assert reset while in STEP with BPCFG programmed: all outputs 0 immediately (asynchronous), BPCFG reads 0, and state is RUN after release.
